imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares one synchronous read/write port of the instruction memory between two requesters: the instruction-fetch path (PC side) and a program loader/debug agent.
- Issues at most one access per cycle. Routes read data back to the requester that issued the read, one cycle after the grant.
- Provides a hold/drain handshake so the loader can stop fetch entirely, and a starvation limit so the loader always makes progress.
- Sits between the core fetch stage / loader and the memory port.

Parameters:
- DATA_WIDTH, 32, width of an instruction/memory word.
- ADDR_WIDTH, 11, word-address width of the memory port.
- MAX_STARVE, 4, consecutive cycles a loader request may lose to fetch before it is forced through (range 1..15).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_WIDTH  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_WIDTH  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  ADDR_WIDTH  loader word address.
- l_wdata  in  DATA_WIDTH  loader write data.
- l_gnt  out  1  loader request accepted this cycle (combinational).
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_WIDTH  loader read data.
- l_hold  in  1  loader requests exclusive ownership of the port.
- hold_ack  out  1  exclusive ownership in effect.
- mem_addr  out  ADDR_WIDTH  memory port address (combinational mux).
- mem_wdata  out  DATA_WIDTH  memory port write data.
- mem_we  out  1  memory port write enable.
- mem_q  in  DATA_WIDTH  memory port registered read data (1-cycle latency).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=RUN, starve counter=0, pending read tag cleared.
  - Outputs at reset: f_rvalid=0, l_rvalid=0, hold_ack=0.
  - Grants are forced to 0 and mem_we=0 while rst_n=0.
- Grant rules in RUN:
  - Fetch wins when f_req=1, unless starve counter==MAX_STARVE, in which case a pending l_req wins.
  - Otherwise the loader is granted when l_req=1 and fetch is not granted.
  - f_gnt and l_gnt are never both 1.
- DRAIN and HELD: f_gnt=0 always; l_gnt=l_req.
- Memory port drive:
  - mem_addr/mem_wdata/mem_we follow the granted requester.
  - mem_we = l_gnt & l_we.
  - With no grant: mem_we=0, mem_addr=f_addr, mem_wdata=0.
- Read return, latency exactly 1 cycle:
  - Registered tag: f_rvalid = previous-cycle f_gnt; l_rvalid = previous-cycle (l_gnt & ~l_we).
  - f_rdata and l_rdata = mem_q while their valid is high, 0 otherwise.
  - Writes produce no rvalid.
- Starve counter (RUN only):
  - Increments (saturating at MAX_STARVE) on each cycle with l_req=1 and l_gnt=0.
  - Clears on l_gnt, or when l_req=0.
  - Held at 0 outside RUN.
- FSM transitions:
  - RUN -> DRAIN when l_hold=1.
  - DRAIN -> HELD after one cycle, once any fetch read granted in the RUN cycle has returned; f_rvalid may be 1 during DRAIN.
  - HELD: hold_ack=1.
  - HELD -> RUN on the cycle l_hold=0; hold_ack drops the same edge.
  - DRAIN -> RUN directly if l_hold drops during DRAIN.
- Boundary cases:
  - l_req and l_hold asserted in the same RUN cycle: arbitration is normal that cycle; the hold takes effect the next cycle.
  - Reset mid-read: the pending rvalid is discarded and no stale data is presented.
  - Back-to-back grants every cycle are legal; the read/rvalid pipeline is fully overlapped.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined: adds outputs stat_fetch_cnt [31:0] and stat_load_cnt [31:0].
  - They count f_gnt and l_gnt cycles respectively.
  - They wrap modulo 2^32 and are cleared by reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with f_req=1 and l_req=1 -> f_gnt=l_gnt=0, mem_we=0, f_rvalid=l_rvalid=hold_ack=0; first cycle after release grants fetch.
- Fetch stream: f_req=1 with f_addr=0,1,2,3 on consecutive cycles, memory preloaded 0xE3A00001.. -> f_rvalid=1 on cycles 1..4 with f_rdata matching each address in order.
- Starvation (MAX_STARVE=4): f_req and l_req held 1 (loader read addr 0x10) -> fetch granted 4 cycles, l_gnt on the 5th, l_rvalid with ram[0x10] on the 6th; the pattern then repeats.
- Hold/load: l_hold=1 mid fetch stream -> one DRAIN cycle delivers the last f_rvalid, then hold_ack=1 and f_gnt=0. Loader write 0xDEADBEEF to 0x7FF, then read 0x7FF -> l_rdata=0xDEADBEEF. Drop l_hold -> hold_ack=0 and fetch resumes the next cycle.
- Reset mid-operation: rst_n=0 the cycle after a loader read grant -> l_rvalid stays 0, state RUN, starve counter 0.
- With IMEM_ARB_STATS_EN: 10 fetch grants and 3 loader grants -> stat_fetch_cnt=10, stat_load_cnt=3.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbitrates one instruction-memory port between fetch and a loader, with hold/drain and starvation guard.
// Optional grant statistics counters are enabled with `define IMEM_ARB_STATS_EN.
module imem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  input  logic                  l_hold,
  output logic                  hold_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_fetch_cnt,
  output logic [31:0]           stat_load_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HELD} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t     state;
  logic [3:0] starve;
  logic       f_tag;
  logic       l_tag;

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (state == S_RUN) begin
        if (f_req && !(l_req && starve == STARVE_MAX)) f_gnt = 1'b1;
        else                                            l_gnt = l_req;
      end else begin
        l_gnt = l_req;
      end
    end
  end

  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = l_gnt ? l_addr : f_addr;
  assign mem_wdata = l_gnt ? l_wdata : '0;

  // Gating with rst_n keeps a read granted just before reset from surfacing during it.
  assign f_rvalid = f_tag & rst_n;
  assign l_rvalid = l_tag & rst_n;
  assign f_rdata  = f_rvalid ? mem_q : '0;
  assign l_rdata  = l_rvalid ? mem_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_RUN;
      starve   <= '0;
      f_tag    <= 1'b0;
      l_tag    <= 1'b0;
      hold_ack <= 1'b0;
    end else begin
      f_tag <= f_gnt;
      l_tag <= l_gnt & ~l_we;
      case (state)
        S_RUN: begin
          if (l_gnt || !l_req)          starve <= '0;
          else if (starve != STARVE_MAX) starve <= starve + 4'd1;
          if (l_hold) begin
            state  <= S_DRAIN;
            starve <= '0;
          end
        end
        // One cycle lets the last RUN-cycle fetch read return before exclusivity.
        S_DRAIN: begin
          starve <= '0;
          if (l_hold) begin
            state    <= S_HELD;
            hold_ack <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_HELD: begin
          starve <= '0;
          if (!l_hold) begin
            state    <= S_RUN;
            hold_ack <= 1'b0;
          end
        end
        default: begin
          state    <= S_RUN;
          starve   <= '0;
          hold_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetch_cnt <= '0;
      stat_load_cnt  <= '0;
    end else begin
      stat_fetch_cnt <= stat_fetch_cnt + {31'b0, f_gnt};
      stat_load_cnt  <= stat_load_cnt + {31'b0, l_gnt};
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed vectors push expected read data, a monitor pops on rvalid.
// Stats ports are checked when IMEM_ARB_STATS_EN is defined.
module tb_imem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [10:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [10:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_hold;
  logic        hold_ack;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_q;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_load_cnt;
`endif

  logic [31:0] ram [0:2047];
  logic [31:0] f_q [$];
  logic [31:0] l_q [$];
  int tests = 0;
  int fails = 0;
  int exp_fcnt = 0;
  int exp_lcnt = 0;

  imem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MAX_STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_hold(l_hold), .hold_ack(hold_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
`ifdef IMEM_ARB_STATS_EN
    , .stat_fetch_cnt(stat_fetch_cnt), .stat_load_cnt(stat_load_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 2048; i++) ram[i] = 32'hE3A00001 + i;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected data whenever the DUT presents read data.
  always @(negedge clk) begin
    if (f_rvalid === 1'b1) begin
      if (f_q.size() == 0) chk("f_rvalid_unexpected", 32'd1, 32'd0);
      else                 chk("f_rdata", f_rdata, f_q.pop_front());
    end else begin
      chk("f_rdata_idle", f_rdata, 32'd0);
    end
    if (l_rvalid === 1'b1) begin
      if (l_q.size() == 0) chk("l_rvalid_unexpected", 32'd1, 32'd0);
      else                 chk("l_rdata", l_rdata, l_q.pop_front());
    end else begin
      chk("l_rdata_idle", l_rdata, 32'd0);
    end
  end

  task automatic step(input logic rst, input logic fr, input logic [10:0] fa,
                      input logic lr, input logic lw, input logic [10:0] la,
                      input logic [31:0] lwd, input logic lh,
                      input logic ef, input logic el, input logic eh,
                      input logic push, input logic [31:0] eld);
    @(posedge clk);
    #1;
    rst_n = rst; f_req = fr; f_addr = fa; l_req = lr; l_we = lw;
    l_addr = la; l_wdata = lwd; l_hold = lh;
    #2;
    chk("f_gnt", {31'b0, f_gnt}, {31'b0, ef});
    chk("l_gnt", {31'b0, l_gnt}, {31'b0, el});
    chk("hold_ack", {31'b0, hold_ack}, {31'b0, eh});
    chk("mem_we", {31'b0, mem_we}, {31'b0, el & lw});
    chk("mem_addr", {21'b0, mem_addr}, {21'b0, el ? la : fa});
    chk("mem_wdata", mem_wdata, el ? lwd : 32'd0);
    if (!rst) begin
      chk("f_rvalid_rst", {31'b0, f_rvalid}, 32'd0);
      chk("l_rvalid_rst", {31'b0, l_rvalid}, 32'd0);
      exp_fcnt = 0;
      exp_lcnt = 0;
    end else begin
      exp_fcnt += int'(ef);
      exp_lcnt += int'(el);
    end
    if (push && ef) f_q.push_back(32'hE3A00001 + {21'b0, fa});
    if (push && el && !lw) l_q.push_back(eld);
  endtask

  initial begin
    logic [9:0] pat;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_hold = 1'b0;

    // Reset with both requesting (loader write): nothing granted.
    repeat (2) step(0, 1, 11'd0, 1, 1, 11'd5, 32'hAA, 0, 0, 0, 0, 0, 0);

    // Fetch stream 0..3, first cycle after release grants fetch.
    for (int a = 0; a < 4; a++) step(1, 1, 11'(a), 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation: fetch four times, loader on the fifth, repeating.
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++)
      step(1, 1, 11'(32 + i), 1, 0, 11'h010, 0, 0, ~pat[i], pat[i], 0, 1, 32'hE3A00011);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Hold mid fetch stream, loader write/read, release.
    step(1, 1, 11'd4, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 1, 11'd5, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    step(1, 1, 11'd6, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 11'd6, 1, 1, 11'h7FF, 32'hDEADBEEF, 1, 0, 1, 1, 1, 0);
    step(1, 1, 11'd6, 1, 0, 11'h7FF, 0, 1, 0, 1, 1, 1, 32'hDEADBEEF);
    step(1, 1, 11'd6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 11'd6, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // l_req with l_hold in RUN: normal grant; hold dropped during DRAIN returns to RUN.
    step(1, 0, 0, 1, 0, 11'h010, 0, 1, 0, 1, 0, 1, 32'hE3A00011);
    step(1, 1, 11'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 11'd7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // Reset the cycle after a loader read grant: its rvalid is discarded.
    step(1, 0, 0, 1, 0, 11'h010, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pat = 10'b0000010000;
    for (int i = 0; i < 5; i++)
      step(1, 1, 11'(64 + i), 1, 0, 11'h010, 0, 0, ~pat[i], pat[i], 0, 1, 32'hE3A00011);
    // Ten fetch grants and three loader grants since the last reset.
    for (int i = 0; i < 6; i++) step(1, 1, 11'(80 + i), 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 11'h100, 32'h12345678, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 11'h100, 0, 0, 0, 1, 0, 1, 32'h12345678);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    chk("f_q_drained", f_q.size(), 32'd0);
    chk("l_q_drained", l_q.size(), 32'd0);
`ifdef IMEM_ARB_STATS_EN
    chk("stat_fetch_cnt", stat_fetch_cnt, 32'(exp_fcnt));
    chk("stat_load_cnt", stat_load_cnt, 32'(exp_lcnt));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
